// File: rtl/mdio_pkg.sv
// rtl/mdio_pkg.sv - MDIO master shared types and frame constants
package mdio_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_HDR,
      S_TA,
      S_DATA,
      S_DONE
   } state_t;

   localparam logic [1:0] ST    = 2'b01;
   localparam logic [1:0] OP_WR = 2'b01;
   localparam logic [1:0] OP_RD = 2'b10;

   localparam logic [5:0] PRE_LEN  = 6'd32;
   localparam logic [5:0] HDR_LEN  = 6'd14;
   localparam logic [5:0] TA_LEN   = 6'd2;
   localparam logic [5:0] DATA_LEN = 6'd16;

endpackage

// File: rtl/mdio_clkgen.sv
// rtl/mdio_clkgen.sv - MDC divider with single-cycle rise/fall strobes
module mdio_clkgen #(
   parameter int CLK_DIV = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic mdc,
   output logic rise,
   output logic fall
);

   localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

   logic [7:0] cnt;
   logic       wrap;

   // Strobes coincide with the clk edge on which mdc itself toggles.
   assign wrap = en && (cnt == DIV_M1);
   assign rise = wrap && !mdc;
   assign fall = wrap && mdc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         mdc <= 1'b0;
      end else if (!en) begin
         cnt <= '0;
         mdc <= 1'b0;
      end else if (wrap) begin
         cnt <= '0;
         mdc <= ~mdc;
      end else begin
         cnt <= cnt + 8'd1;
      end
   end

endmodule

// File: rtl/mdio_master.sv
// rtl/mdio_master.sv - Clause-22 MDIO management master (read/write frames)
// Optional MDIO_PRE_SUPPRESS_EN adds cfg_no_pre to skip the 32-bit preamble.
module mdio_master
   import mdio_pkg::*;
#(
   parameter int CLK_DIV = 20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [4:0]  req_phy,
   input  logic [4:0]  req_reg,
   input  logic [15:0] req_wdata,
`ifdef MDIO_PRE_SUPPRESS_EN
   input  logic        cfg_no_pre,
`endif
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mdc,
   output logic        mdio_o,
   output logic        mdio_hiz,
   input  logic        mdio_i
);

   state_t      state, state_n, seg_nxt;
   logic [5:0]  bit_cnt, cnt_n;
   logic        seg_end, in_frame, accept, no_pre;
   logic        clk_en, rise, fall;
   logic        wr_q;
   logic [4:0]  phy_q, reg_q;
   logic [15:0] wdata_q, rd_shift;
   logic        ta_err;
   logic [1:0]  sync;
   logic [13:0] hdr;
   logic        pad_o_n, pad_hiz_n;

`ifdef MDIO_PRE_SUPPRESS_EN
   assign no_pre = cfg_no_pre;
`else
   assign no_pre = 1'b0;
`endif

   assign req_ready = (state == S_IDLE);
   assign accept    = req_valid && req_ready;
   assign clk_en    = (state != S_IDLE);
   assign rsp_valid = (state == S_DONE);
   assign in_frame  = (state == S_PRE) || (state == S_HDR) ||
                      (state == S_TA)  || (state == S_DATA);
   assign hdr       = {ST, (wr_q ? OP_WR : OP_RD), phy_q, reg_q};

   mdio_clkgen #(
      .CLK_DIV (CLK_DIV)
   ) u_clkgen (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (clk_en),
      .mdc   (mdc),
      .rise  (rise),
      .fall  (fall)
   );

   always_comb begin
      state_n = state;
      cnt_n   = bit_cnt;
      seg_end = 1'b0;
      seg_nxt = S_IDLE;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_n = no_pre ? S_HDR : S_PRE;
               cnt_n   = '0;
            end
         end
         S_PRE: begin
            seg_end = (bit_cnt == PRE_LEN - 6'd1);
            seg_nxt = S_HDR;
         end
         S_HDR: begin
            seg_end = (bit_cnt == HDR_LEN - 6'd1);
            seg_nxt = S_TA;
         end
         S_TA: begin
            seg_end = (bit_cnt == TA_LEN - 6'd1);
            seg_nxt = S_DATA;
         end
         S_DATA: begin
            seg_end = (bit_cnt == DATA_LEN - 6'd1);
            seg_nxt = S_DONE;
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
      // Bits advance only on MDC falling edges.
      if (fall && in_frame) begin
         if (seg_end) begin
            state_n = seg_nxt;
            cnt_n   = '0;
         end else begin
            cnt_n = bit_cnt + 6'd1;
         end
      end
   end

   // Pad value for the bit that starts with the upcoming state/count.
   always_comb begin
      pad_hiz_n = 1'b1;
      pad_o_n   = 1'b1;
      case (state_n)
         S_PRE: pad_hiz_n = 1'b0;
         S_HDR: begin
            pad_hiz_n = 1'b0;
            pad_o_n   = hdr[4'd13 - cnt_n[3:0]];
         end
         S_TA: begin
            if (wr_q) begin
               pad_hiz_n = 1'b0;
               pad_o_n   = (cnt_n == 6'd0);
            end
         end
         S_DATA: begin
            if (wr_q) begin
               pad_hiz_n = 1'b0;
               pad_o_n   = wdata_q[4'd15 - cnt_n[3:0]];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         bit_cnt   <= '0;
         wr_q      <= 1'b0;
         phy_q     <= '0;
         reg_q     <= '0;
         wdata_q   <= '0;
         mdio_o    <= 1'b1;
         mdio_hiz  <= 1'b1;
         sync      <= 2'b11;
         rd_shift  <= '0;
         ta_err    <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state   <= state_n;
         bit_cnt <= cnt_n;
         sync    <= {sync[0], mdio_i};
         if (accept) begin
            wr_q    <= req_write;
            phy_q   <= req_phy;
            reg_q   <= req_reg;
            wdata_q <= req_wdata;
            ta_err  <= 1'b0;
         end
         if (accept || fall) begin
            mdio_o   <= pad_o_n;
            mdio_hiz <= pad_hiz_n;
         end
         if (rise && !wr_q) begin
            // A PHY that is present pulls the second turnaround bit low.
            if (state == S_TA && bit_cnt == TA_LEN - 6'd1)
               ta_err <= sync[1];
            if (state == S_DATA)
               rd_shift <= {rd_shift[14:0], sync[1]};
         end
         if (state == S_DATA && state_n == S_DONE) begin
            rsp_err <= !wr_q && ta_err;
            if (!wr_q)
               rsp_rdata <= rd_shift;
         end
      end
   end

endmodule

// File: tb/tb_mdio_master.sv
// tb/tb_mdio_master.sv - scoreboard bench for mdio_master with a PHY model
`timescale 1ns/1ps
module tb_mdio_master;

   localparam int CLK_DIV = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_write;
   logic [4:0]  req_phy, req_reg;
   logic [15:0] req_wdata;
   logic        rsp_valid, rsp_err;
   logic [15:0] rsp_rdata;
   logic        mdc, mdio_o, mdio_hiz;
   logic        mdio_i = 1'b1;
`ifdef MDIO_PRE_SUPPRESS_EN
   logic        cfg_no_pre;
`endif

   always #5 clk = ~clk;

   mdio_master #(.CLK_DIV(CLK_DIV)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_phy   (req_phy),
      .req_reg   (req_reg),
      .req_wdata (req_wdata),
`ifdef MDIO_PRE_SUPPRESS_EN
      .cfg_no_pre(cfg_no_pre),
`endif
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .mdc       (mdc),
      .mdio_o    (mdio_o),
      .mdio_hiz  (mdio_hiz),
      .mdio_i    (mdio_i)
   );

   typedef struct {
      logic        wr;
      logic [63:0] o;
      logic [63:0] hiz;
      int          nbits;
      logic [15:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   // mode: 0 = PHY answers, 1 = PHY absent (pull-up), 2 = PHY answers but TA bit 2 high
   typedef struct {
      int          mode;
      logic [15:0] data;
   } phy_t;

   exp_t        expq[$];
   phy_t        phyq[$];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] model_rdata = 16'h0000;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   task automatic mk_exp(input logic wr, input logic [4:0] phy, input logic [4:0] rg,
                         input logic [15:0] wd, input int mode, input logic [15:0] pd,
                         input logic nopre, output exp_t e);
      logic [13:0] hdr;
      logic [17:0] tail, tail_hz;
      logic [63:0] full_o, full_hz;
      hdr     = {2'b01, (wr ? 2'b01 : 2'b10), phy, rg};
      tail    = wr ? {2'b10, wd} : 18'h3FFFF;
      tail_hz = wr ? 18'h0 : 18'h3FFFF;
      full_o  = {32'hFFFF_FFFF, hdr, tail};
      full_hz = {46'h0, tail_hz};
      e.wr    = wr;
      e.nbits = nopre ? 32 : 64;
      e.o     = nopre ? {32'h0, full_o[31:0]} : full_o;
      e.hiz   = nopre ? {32'h0, full_hz[31:0]} : full_hz;
      e.lat   = e.nbits * 2 * CLK_DIV + 1;
      if (wr) begin
         e.rdata = model_rdata;
         e.err   = 1'b0;
      end else begin
         e.rdata     = (mode == 1) ? 16'hFFFF : pd;
         e.err       = (mode != 0);
         model_rdata = e.rdata;
      end
   endtask

   // ---------------- PHY model: presents each bit after an MDC falling edge
   phy_t cp;
   int   pbit = 0;
   logic prev_mdc_p = 1'b0;

   function automatic logic phy_drive(input phy_t p, input int b);
      logic [15:0] d;
      d = p.data;
      if (p.mode == 1 || b < 46 || b > 63) return 1'b1;
      if (b == 46) return 1'b1;
      if (b == 47) return (p.mode == 2);
      return d[63 - b];
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         pbit    = 0;
         cp.mode = 1;
         cp.data = 16'h0;
         mdio_i  = 1'b1;
      end else begin
         if (req_valid && req_ready) begin
            if (phyq.size() > 0) cp = phyq.pop_front();
            pbit = 0;
         end else if (prev_mdc_p && !mdc) begin
            pbit++;
         end
         mdio_i = phy_drive(cp, pbit);
      end
      prev_mdc_p = mdc;
   end

   // ---------------- Monitor / scoreboard
   int          cyc = 0, acc_cyc = 0, last_rsp_cyc = -100, last_acc_gap = 0;
   int          cur_bit = 0, nobs = 0, viol = 0;
   logic        in_frame = 1'b0;
   logic [63:0] obs_o = '0, obs_hz = '0;
   logic        prev_mdc = 1'b0, prev_o = 1'b1, prev_hz = 1'b1, prev_ready = 1'b1, prev_rst = 1'b0;
   exp_t        cur_e;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n || !prev_rst) begin
         nobs     = 0;
         cur_bit  = 0;
         in_frame = 1'b0;
         obs_o    = '0;
         obs_hz   = '0;
      end else begin
         if ((mdio_o !== prev_o || mdio_hiz !== prev_hz) && !(prev_mdc && !mdc) && !prev_ready)
            viol++;
         if (mdc && !prev_mdc) begin
            obs_o  = {obs_o[62:0], mdio_o};
            obs_hz = {obs_hz[62:0], mdio_hiz};
            nobs++;
         end
         if (prev_mdc && !mdc) cur_bit++;
         if (rsp_valid) begin
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_rsp: actual rsp_valid=1 required no pending request");
            end else begin
               cur_e = expq.pop_front();
               chk("latency", 64'(cyc - acc_cyc), 64'(cur_e.lat));
               chk("rsp_rdata", {48'h0, rsp_rdata}, {48'h0, cur_e.rdata});
               chk("rsp_err", {63'h0, rsp_err}, {63'h0, cur_e.err});
               chk("frame_bits", 64'(nobs), 64'(cur_e.nbits));
               chk("pad_o", obs_o & ~cur_e.hiz, cur_e.o & ~cur_e.hiz);
               chk("pad_hiz", obs_hz, cur_e.hiz);
               chk("hiz_in_done", {63'h0, mdio_hiz}, 64'h1);
               chk("pad_change_off_fall", 64'(viol), 64'h0);
            end
            last_rsp_cyc = cyc;
            in_frame     = 1'b0;
         end
         if (req_valid && req_ready) begin
            chk("accept_while_busy", {63'h0, in_frame}, 64'h0);
            last_acc_gap = cyc - last_rsp_cyc;
            acc_cyc  = cyc;
            in_frame = 1'b1;
            nobs     = 0;
            cur_bit  = 0;
            viol     = 0;
            obs_o    = '0;
            obs_hz   = '0;
         end
      end
      prev_mdc   = mdc;
      prev_o     = mdio_o;
      prev_hz    = mdio_hiz;
      prev_ready = req_ready;
      prev_rst   = rst_n;
   end

   // ---------------- Driver
   task automatic issue(input logic wr, input logic [4:0] phy, input logic [4:0] rg,
                        input logic [15:0] wd, input int mode, input logic [15:0] pd,
                        input logic nopre, input bit keep);
      exp_t e;
      phy_t p;
      int   budget;
      mk_exp(wr, phy, rg, wd, mode, pd, nopre, e);
      expq.push_back(e);
      p.mode = wr ? 1 : mode;
      p.data = pd;
      phyq.push_back(p);
      @(posedge clk);
      #1;
      req_write = wr;
      req_phy   = phy;
      req_reg   = rg;
      req_wdata = wd;
`ifdef MDIO_PRE_SUPPRESS_EN
      cfg_no_pre = nopre;
`endif
      req_valid = 1'b1;
      budget = 3000;
      while (!req_ready && budget > 0) begin
         @(posedge clk);
         #1;
         budget--;
      end
      if (budget == 0) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: actual req_ready=0 required 1 within 3000 cycles");
         req_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         if (!keep) req_valid = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int budget;
      budget = 3000;
      while (expq.size() != 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) begin
         checks++;
         errors++;
         $display("FAIL completion_timeout: actual %0d pending required 0", expq.size());
         expq.delete();
         phyq.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int budget;
      logic wr;
      int   mode;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_phy   = '0;
      req_reg   = '0;
      req_wdata = '0;
`ifdef MDIO_PRE_SUPPRESS_EN
      cfg_no_pre = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("reset_mdc", {63'h0, mdc}, 64'h0);
      chk("reset_mdio_o", {63'h0, mdio_o}, 64'h1);
      chk("reset_mdio_hiz", {63'h0, mdio_hiz}, 64'h1);
      chk("reset_rsp_valid", {63'h0, rsp_valid}, 64'h0);
      chk("reset_rsp_err", {63'h0, rsp_err}, 64'h0);
      chk("reset_rsp_rdata", {48'h0, rsp_rdata}, 64'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_reset", {63'h0, req_ready}, 64'h1);

      issue(1'b1, 5'h01, 5'h00, 16'h8000, 1, 16'h0, 1'b0, 1'b0);
      wait_idle();
      issue(1'b0, 5'h1F, 5'h02, 16'h0, 0, 16'h0141, 1'b0, 1'b0);
      wait_idle();
      issue(1'b0, 5'($urandom), 5'($urandom), 16'h0, 1, 16'($urandom), 1'b0, 1'b0);
      wait_idle();
      issue(1'b0, 5'($urandom), 5'($urandom), 16'h0, 2, 16'($urandom), 1'b0, 1'b0);
      wait_idle();

      // req_valid stays high across the first frame into the second request
      issue(1'b1, 5'($urandom), 5'($urandom), 16'($urandom), 1, 16'h0, 1'b0, 1'b1);
      issue(1'b0, 5'($urandom), 5'($urandom), 16'h0, 0, 16'($urandom), 1'b0, 1'b0);
      chk("accept_after_rsp", 64'(last_acc_gap), 64'h1);
      wait_idle();

      // Reset during bit 40 of a write, while MDC is high
      issue(1'b1, 5'($urandom), 5'($urandom), 16'($urandom), 1, 16'h0, 1'b0, 1'b0);
      budget = 3000;
      while (!(cur_bit == 40 && mdc) && budget > 0) begin
         @(posedge clk);
         #2;
         budget--;
      end
      chk("reach_bit40", 64'(cur_bit), 64'd40);
      rst_n = 1'b0;
      #1;
      chk("abort_hiz", {63'h0, mdio_hiz}, 64'h1);
      chk("abort_mdc", {63'h0, mdc}, 64'h0);
      chk("abort_rsp_valid", {63'h0, rsp_valid}, 64'h0);
      void'(expq.pop_back());
      model_rdata = 16'h0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      issue(1'b1, 5'($urandom), 5'($urandom), 16'($urandom), 1, 16'h0, 1'b0, 1'b0);
      wait_idle();

`ifdef MDIO_PRE_SUPPRESS_EN
      issue(1'b1, 5'($urandom), 5'($urandom), 16'($urandom), 1, 16'h0, 1'b1, 1'b0);
      wait_idle();
`endif

      for (int i = 0; i < 5; i++) begin
         wr   = 1'($urandom_range(0, 1));
         mode = $urandom_range(0, 2);
         issue(wr, 5'($urandom), 5'($urandom), 16'($urandom), mode, 16'($urandom), 1'b0, 1'b0);
         wait_idle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
